// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants and state type for the input debouncer
//
// Purpose: state encoding and default qualification length shared by
//          input_debouncer and anything that decodes its state.
// Ports:   none (package)

package debounce_pkg;

  // Default number of consecutive synchronized samples that qualify a new level.
  localparam int DEF_STABLE_CYCLES = 4;

  localparam logic [1:0] ST_STABLE_LOW  = 2'd0;
  localparam logic [1:0] ST_PEND_HIGH   = 2'd1;
  localparam logic [1:0] ST_STABLE_HIGH = 2'd2;
  localparam logic [1:0] ST_PEND_LOW    = 2'd3;

  typedef enum logic [1:0] {
    S_STABLE_LOW  = ST_STABLE_LOW,
    S_PEND_HIGH   = ST_PEND_HIGH,
    S_STABLE_HIGH = ST_STABLE_HIGH,
    S_PEND_LOW    = ST_PEND_LOW
  } deb_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-stage synchronizer for a single asynchronous bit
//
// Purpose: brings an asynchronous level into the clk domain through two
//          flops; the first flop may go metastable and is never used directly.
// Ports:
//   clk    - system clock, rising-edge active
//   reset  - asynchronous active-low reset, clears both stages
//   d      - asynchronous input bit
//   q      - synchronized output (second stage)

module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronize and debounce a raw input, with edge pulses
//
// Purpose: turns a glitchy asynchronous input into a clean clk-synchronous
//          level (q) that only changes after STABLE_CYCLES consecutive
//          synchronized samples of the new level. One-cycle rise/fall pulses
//          accompany each change of q.
// Optional: DEBOUNCE_EDGE_CNT_EN adds an 8-bit wrapping count of accepted
//          rising edges (edge_cnt).
// Ports:
//   clk      - system clock, rising-edge active
//   reset    - asynchronous active-low reset
//   din      - raw asynchronous input, may glitch
//   q        - debounced level
//   rise     - one-cycle pulse, same cycle q goes 0->1
//   fall     - one-cycle pulse, same cycle q goes 1->0
//   edge_cnt - accepted rising-edge count (DEBOUNCE_EDGE_CNT_EN only)

module input_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic       q,
  output logic       rise,
  output logic       fall
`ifdef DEBOUNCE_EDGE_CNT_EN
  ,
  output logic [7:0] edge_cnt
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  // Counter value at which the current sample is the last one needed.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             w_sync;
  deb_state_t       r_state;
  deb_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_q;
  logic             r_rise;
  logic             r_fall;
  logic             w_q_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din),
    .q     (w_sync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_STABLE_LOW;
      r_cnt   <= '0;
      r_q     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // The counter is cleared on every path except while a PEND state keeps
  // seeing the candidate level, so any reversal restarts qualification.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_q_nxt     = r_q;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      S_STABLE_LOW: begin
        if (w_sync) begin
          w_state_nxt = S_PEND_HIGH;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      S_PEND_HIGH: begin
        if (!w_sync) begin
          w_state_nxt = S_STABLE_LOW;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_STABLE_HIGH;
          w_q_nxt     = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_STABLE_HIGH: begin
        if (!w_sync) begin
          w_state_nxt = S_PEND_LOW;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      S_PEND_LOW: begin
        if (w_sync) begin
          w_state_nxt = S_STABLE_HIGH;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_STABLE_LOW;
          w_q_nxt     = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_STABLE_LOW;
      end
    endcase
  end

  assign q    = r_q;
  assign rise = r_rise;
  assign fall = r_fall;

`ifdef DEBOUNCE_EDGE_CNT_EN
  logic [7:0] r_edge_cnt;

  // Counts in the same cycle rise is registered, so edge_cnt and q agree.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_edge_cnt <= 8'd0;
    end else if (w_rise_nxt) begin
      r_edge_cnt <= r_edge_cnt + 8'd1;
    end
  end

  assign edge_cnt = r_edge_cnt;
`endif

endmodule
